// File: rtl/kalman_predict_unit.sv
// Kalman filter time-update stage for a 6-state constant-velocity model.
// X' = F*X and P' = F*P*F^T + Q, one covariance element per cycle.
module kalman_predict_unit #(
   parameter int W    = 16,
   parameter int FRAC = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    dt,
   input  logic [W-1:0]    q_pos,
   input  logic [W-1:0]    q_vel,
   input  logic [6*W-1:0]  x_in,
   input  logic [36*W-1:0] p_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [6*W-1:0]  x_pred,
   output logic [36*W-1:0] p_pred
);

   // state | meaning
   // IDLE  | waiting for an input bundle, in_ready=1
   // DT2   | squaring dt into dt2 (saturated unsigned)
   // XP    | writing predicted states, clearing idx
   // COV   | writing p_pred[idx], one element per cycle
   // DONE  | results valid, holding until out_ready

   localparam int PW = 2*W + 2;
   localparam int SW = 2*W + 4;
   localparam logic signed [SW-1:0] SMAX = SW'((2**(W-1)) - 1);
   localparam logic signed [SW-1:0] SMIN = -SMAX - 1;

   typedef enum logic [2:0] {IDLE, DT2, XP, COV, DONE} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     dt_r, qp_r, qv_r, dt2_r;
   logic [6*W-1:0]   x_r;
   logic [36*W-1:0]  p_r;
   logic [5:0]       idx;

   logic [2*W-1:0]   dt_sq, dt_sq_sh;
   logic [W-1:0]     dt2_d;
   logic [6*W-1:0]   xp_d;
   logic [2:0]       row, col;
   int               k;
   logic signed [SW-1:0] acc;
   logic [W-1:0]     pe_d;

   function automatic logic signed [SW-1:0] sext(input logic [W-1:0] v);
      return {{(SW-W){v[W-1]}}, v};
   endfunction

   // Unsigned coefficient times signed element, floor-shifted back to the element scale.
   function automatic logic signed [SW-1:0] mul_q(input logic [W-1:0] a,
                                                  input logic [W-1:0] p);
      logic signed [PW-1:0] aa, pp, prod;
      aa   = {{(PW-W){1'b0}}, a};
      pp   = {{(PW-W){p[W-1]}}, p};
      prod = aa * pp;
      prod = prod >>> FRAC;
      return {{(SW-PW){prod[PW-1]}}, prod};
   endfunction

   function automatic logic [W-1:0] sat(input logic signed [SW-1:0] s);
      if (s > SMAX)
         return {1'b0, {(W-1){1'b1}}};
      else if (s < SMIN)
         return {1'b1, {(W-1){1'b0}}};
      else
         return s[W-1:0];
   endfunction

   always_comb begin
      dt_sq    = dt_r * dt_r;
      dt_sq_sh = dt_sq >> FRAC;
      dt2_d    = (|dt_sq_sh[2*W-1:W]) ? '1 : dt_sq_sh[W-1:0];
   end

   always_comb begin
      xp_d = x_r;
      for (int i = 0; i < 3; i++)
         xp_d[W*i +: W] = sat(sext(x_r[W*i +: W]) + mul_q(dt_r, x_r[W*(i+3) +: W]));
   end

   // Offsets +3, +18, +21 reach P[r][c+3], P[r+3][c], P[r+3][c+3] in row-major order.
   always_comb begin
      k   = int'(idx);
      row = 3'(idx / 6'd6);
      col = 3'(idx % 6'd6);
      acc = sext(p_r[W*k +: W]);
      if (col < 3'd3)
         acc = acc + mul_q(dt_r, p_r[W*(k+3) +: W]);
      if (row < 3'd3)
         acc = acc + mul_q(dt_r, p_r[W*(k+18) +: W]);
      if (row < 3'd3 && col < 3'd3)
         acc = acc + mul_q(dt2_r, p_r[W*(k+21) +: W]);
      if (row == col)
         acc = acc + sext((row < 3'd3) ? qp_r : qv_r);
      pe_d = sat(acc);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = DT2;
         end
         DT2:  state_d = XP;
         XP:   state_d = COV;
         COV:  if (idx == 6'd35) state_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dt_r   <= '0;
         qp_r   <= '0;
         qv_r   <= '0;
         dt2_r  <= '0;
         x_r    <= '0;
         p_r    <= '0;
         idx    <= '0;
         x_pred <= '0;
         p_pred <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  dt_r <= dt;
                  qp_r <= q_pos;
                  qv_r <= q_vel;
                  x_r  <= x_in;
                  p_r  <= p_in;
               end
            end
            DT2: dt2_r <= dt2_d;
            XP: begin
               x_pred <= xp_d;
               idx    <= '0;
            end
            COV: begin
               p_pred[W*k +: W] <= pe_d;
               idx              <= idx + 6'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_kalman_predict_unit.sv
// Directed testbench for kalman_predict_unit with hand-computed expected values.
module tb_kalman_predict_unit;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [15:0]  dt = '0, q_pos = '0, q_vel = '0;
   logic [95:0]  x_in = '0;
   logic [575:0] p_in = '0;
   logic         in_ready, out_valid;
   logic [95:0]  x_pred;
   logic [575:0] p_pred;

   int vectors = 0;
   int errors  = 0;

   kalman_predict_unit dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .dt(dt), .q_pos(q_pos), .q_vel(q_vel), .x_in(x_in), .p_in(p_in),
      .out_valid(out_valid), .out_ready(out_ready), .x_pred(x_pred), .p_pred(p_pred)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int gx(input int i);
      return int'($signed(x_pred[16*i +: 16]));
   endfunction

   function automatic int gp(input int i);
      return int'($signed(p_pred[16*i +: 16]));
   endfunction

   task automatic load_bundle(input logic [15:0] d, input int qp, input int qv, input int xv[6]);
      dt    = d;
      q_pos = 16'(qp);
      q_vel = 16'(qv);
      for (int i = 0; i < 6; i++) x_in[16*i +: 16] = 16'(xv[i]);
      p_in = '0;
   endtask

   task automatic set_p(input int i, input int v);
      p_in[16*i +: 16] = 16'(v);
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
   task automatic start_job();
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // n counts edges from the accept edge (n=1) to the first edge after which out_valid is seen.
   task automatic wait_valid(output int n);
      n = 1;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic release_job();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      vectors++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      vectors++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      vectors++;
      if (x_pred !== '0) begin errors++; $display("FAIL reset_x_pred: got %h expected 0", x_pred); end
      vectors++;
      if (p_pred !== '0) begin errors++; $display("FAIL reset_p_pred: nonzero, expected 0"); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_nominal();
      int xv[6] = '{100, 110, 120, 130, 140, 150};
      int ex[6] = '{230, 250, 270, 130, 140, 150};
      int n;
      load_bundle(16'h0100, 0, 0, xv);
      start_job();
      wait_valid(n);
      vectors++;
      if (out_valid !== 1'b1 || n != 39) begin
         errors++; $display("FAIL nominal_latency: got %0d edges (valid=%b) expected 39", n, out_valid);
      end
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (gx(i) !== ex[i]) begin errors++; $display("FAIL nominal_x%0d: got %0d expected %0d", i, gx(i), ex[i]); end
      end
      release_job();
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL nominal_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_covariance();
      int xv[6] = '{0, 0, 0, 0, 0, 0};
      int pk[10] = '{0, 7, 14, 3, 18, 21, 1, 28, 35, 10};
      int pv[10] = '{37, 47, 57, 8, 8, 6, 0, 6, 6, 8};
      int n;
      load_bundle(16'h0200, 1, 2, xv);
      set_p(0, 20); set_p(7, 30); set_p(14, 40);
      set_p(21, 4); set_p(28, 4); set_p(35, 4);
      start_job();
      wait_valid(n);
      vectors++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL cov_timeout: got valid=%b expected 1", out_valid); end
      for (int j = 0; j < 10; j++) begin
         vectors++;
         if (gp(pk[j]) !== pv[j]) begin errors++; $display("FAIL cov_p%0d: got %0d expected %0d", pk[j], gp(pk[j]), pv[j]); end
      end
      release_job();
   endtask

   task automatic test_saturation();
      logic [15:0] tdt[4] = '{16'h0100, 16'h0100, 16'h0080, 16'hFFFF};
      int tx0[4]  = '{32000, -32000, 0, 0};
      int tx3[4]  = '{32000, -32000, -3, 1};
      int tp0[4]  = '{32000, -32000, 0, 0};
      int tp21[4] = '{32000, -32000, -3, 1};
      int tqp[4]  = '{100, -100, 0, 0};
      int ex0[4]  = '{32767, -32768, -2, 255};
      int ep0[4]  = '{32767, -32768, -1, 255};
      int ep3[4]  = '{32000, -32000, -2, 255};
      int xv[6];
      int n;
      for (int j = 0; j < 4; j++) begin
         xv = '{tx0[j], 0, 0, tx3[j], 0, 0};
         load_bundle(tdt[j], tqp[j], 0, xv);
         set_p(0, tp0[j]);
         set_p(21, tp21[j]);
         start_job();
         wait_valid(n);
         vectors++;
         if (out_valid !== 1'b1) begin errors++; $display("FAIL sat%0d_timeout: got valid=%b expected 1", j, out_valid); end
         vectors++;
         if (gx(0) !== ex0[j]) begin errors++; $display("FAIL sat%0d_x0: got %0d expected %0d", j, gx(0), ex0[j]); end
         vectors++;
         if (gx(3) !== tx3[j]) begin errors++; $display("FAIL sat%0d_x3: got %0d expected %0d", j, gx(3), tx3[j]); end
         vectors++;
         if (gp(0) !== ep0[j]) begin errors++; $display("FAIL sat%0d_p0: got %0d expected %0d", j, gp(0), ep0[j]); end
         vectors++;
         if (gp(3) !== ep3[j]) begin errors++; $display("FAIL sat%0d_p3: got %0d expected %0d", j, gp(3), ep3[j]); end
         release_job();
      end
   endtask

   task automatic test_backpressure();
      int xv[6] = '{100, 110, 120, 130, 140, 150};
      int n;
      load_bundle(16'h0100, 0, 0, xv);
      start_job();
      wait_valid(n);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin x_in[15:0] = 16'd7; in_valid = 1'b1; end
         if (i == 5) in_valid = 1'b0;
         vectors++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold%0d: got out_valid=%b in_ready=%b expected 1/0", i, out_valid, in_ready);
         end
         vectors++;
         if (gx(0) !== 230 || gx(2) !== 270) begin
            errors++; $display("FAIL bp_data%0d: got x0=%0d x2=%0d expected 230/270", i, gx(0), gx(2));
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
      vectors++;
      if (gx(0) !== 230) begin errors++; $display("FAIL bp_idle_hold: got %0d expected 230", gx(0)); end
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_pulse_ignored: got in_ready=%b expected 1", in_ready); end
   endtask

   task automatic test_reset_mid();
      int xv[6] = '{100, 110, 120, 130, 140, 150};
      int ex[6] = '{360, 390, 420, 130, 140, 150};
      int pk[4] = '{0, 7, 21, 3};
      int pv[4] = '{37, 47, 6, 8};
      int n;
      load_bundle(16'h0200, 1, 2, xv);
      set_p(0, 20); set_p(7, 30); set_p(14, 40);
      set_p(21, 4); set_p(28, 4); set_p(35, 4);
      start_job();
      repeat (12) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL rstmid_ctrl: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
      vectors++;
      if (x_pred !== '0 || p_pred !== '0) begin errors++; $display("FAIL rstmid_clear: outputs nonzero, expected 0"); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_job();
      wait_valid(n);
      vectors++;
      if (out_valid !== 1'b1 || n != 39) begin
         errors++; $display("FAIL rstmid_latency: got %0d edges (valid=%b) expected 39", n, out_valid);
      end
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (gx(i) !== ex[i]) begin errors++; $display("FAIL rstmid_x%0d: got %0d expected %0d", i, gx(i), ex[i]); end
      end
      for (int j = 0; j < 4; j++) begin
         vectors++;
         if (gp(pk[j]) !== pv[j]) begin errors++; $display("FAIL rstmid_p%0d: got %0d expected %0d", pk[j], gp(pk[j]), pv[j]); end
      end
      release_job();
   endtask

   task automatic test_back_to_back();
      int xa[6] = '{1, 2, 3, 4, 5, 6};
      int xb[6] = '{-50, -60, -70, 10, 20, 30};
      int ex[2][6] = '{'{9, 12, 15, 4, 5, 6}, '{-40, -40, -40, 10, 20, 30}};
      int pk[2][7] = '{'{0, 7, 14, 21, 35, 1, 28}, '{0, 8, 7, 4, 20, 35, 29}};
      int pv[2][7] = '{'{3, 3, 3, -4, -4, 0, -4}, '{47, 74, 75, 26, 43, 42, 29}};
      int acc_t[2] = '{0, 0};
      int na = 0, nh = 0, pend = 0, extra = 0;
      load_bundle(16'h0200, 3, -4, xa);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int t = 0; t < 200 && nh < 2; t++) begin
         if (pend == 1) begin
            load_bundle(16'h0100, 5, 7, xb);
            for (int i = 0; i < 36; i++) set_p(i, i);
         end else if (pend == 2) begin
            in_valid = 1'b0;
         end
         pend = 0;
         if (in_valid && in_ready) begin
            if (na < 2) acc_t[na] = t;
            na++;
            pend = na;
         end
         if (out_valid && out_ready) begin
            for (int i = 0; i < 6; i++) begin
               vectors++;
               if (gx(i) !== ex[nh][i]) begin
                  errors++; $display("FAIL b2b_job%0d_x%0d: got %0d expected %0d", nh, i, gx(i), ex[nh][i]);
               end
            end
            for (int j = 0; j < 7; j++) begin
               vectors++;
               if (gp(pk[nh][j]) !== pv[nh][j]) begin
                  errors++; $display("FAIL b2b_job%0d_p%0d: got %0d expected %0d", nh, pk[nh][j], gp(pk[nh][j]), pv[nh][j]);
               end
            end
            nh++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      vectors++;
      if (na != 2 || nh != 2) begin errors++; $display("FAIL b2b_counts: got accepts=%0d handshakes=%0d expected 2/2", na, nh); end
      vectors++;
      if (acc_t[1] - acc_t[0] != 40) begin errors++; $display("FAIL b2b_period: got %0d expected 40", acc_t[1] - acc_t[0]); end
      repeat (45) begin
         if (out_valid) extra++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      vectors++;
      if (extra != 0) begin errors++; $display("FAIL b2b_extra_valid: got %0d cycles expected 0", extra); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_covariance();
      test_saturation();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
